logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Pipelined, parametrised bitwise logic unit for the RV32i execute stage.
//  Supersedes single-function combinational gates: one block gives AND/OR/XOR and their complements on an N-bit operand pair.
//  Registered result path, 1..N stages; valid/ready handshake with backpressure and bubble collapse.
//  Sits between the operand-select muxes and the writeback mux.
// PARAMETERS
//  nb_bits    32  operand/result width (>=1)
//  nb_stages  2   register stages between input and output (>=1); latency in cycles
// PORTS
//  clk_i        in   1                     clock, all flops on rising edge
//  rst_n_i      in   1                     asynchronous active-low reset
//  in_valid_i   in   1                     operand pair + op presented
//  in_ready_o   out  1                     unit can accept this cycle
//  op_i         in   3                     logic_op_t function select
//  a_i          in   nb_bits               operand A
//  b_i          in   nb_bits               operand B
//  out_valid_o  out  1                     result available
//  out_ready_i  in   1                     consumer takes result this cycle
//  result_o     out  nb_bits               result of oldest in-flight op
//  inflight_o   out  $clog2(nb_stages+1)   number of valid stages
//  busy_o       out  1                     inflight_o != 0
// BEHAVIOUR
//  - Ops: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 ANDN (a & ~b), 111 PASS_A.
//  - Function evaluated combinationally at input; result captured in stage 0; later stages carry data only.
//  - Reset (async assert, sync release): all stage valids=0, all stage data=0.
//    Outputs: out_valid_o=0, result_o=0, inflight_o=0, busy_o=0.
//    in_ready_o=1 from the first cycle after release.
//  - Stage k holds v[k], d[k]; stage nb_stages-1 drives out_valid_o/result_o.
//  - Ready chain: rdy[nb_stages] = out_ready_i; rdy[k] = ~v[k] | rdy[k+1]; in_ready_o = rdy[0].
//  - Stage k loads from k-1 (stage 0 from inputs) when rdy[k]=1; v[k] <= v[k-1] (stage 0: in_valid_i).
//  - Transfer in = in_valid_i & in_ready_o; transfer out = out_valid_o & out_ready_i.
//  - Latency: accepted at edge T -> out_valid_o high after edge T+nb_stages-1, if never stalled.
//  - Throughput 1 op/cycle under continuous out_ready_i=1.
//  - Bubble collapse: a stalled output does not block upstream stages while empty stages exist.
//  - Full: all v=1 and out_ready_i=0 -> in_ready_o=0; no stage changes; result_o stable.
//  - Full with out_ready_i=1: in_ready_o=1 same cycle; accept and deliver together.
//  - inflight_o: +1 on in-only, -1 on out-only, unchanged on both or neither.
//    Never exceeds nb_stages; never underflows.
//  - Inputs are ignored when in_valid_i=0 and are don't-care.
//  - Data of a stage with v=0 holds its last value; it is not re-zeroed.
//  - Reset asserted mid-operation: all in-flight ops discarded immediately, no partial output.
//  - Ordering strictly FIFO; no reordering, no dropping.
//  - out_valid_o must not fall without out_ready_i; result_o must not change while out_valid_o=1 and out_ready_i=0.
// STRUCTURE
//  - Package riscv_logic_pkg: typedef enum logic [2:0] logic_op_t (OP_AND..OP_PASSA, values above).
//    Also function logic_eval(op, a, b) shared with the bench model.
//  - Sub-module logic_pipe_stage #(nb_bits): one valid+data register slot.
//    Ports clk_i, rst_n_i, load_i, valid_i, data_i, valid_o, data_o.
//    Instantiated nb_stages times by a generate loop.
//  - Top holds the function mux, ready chain and inflight counter.
// TESTING
//  - Reset: rst_n_i=0 mid-stream with 2 ops in flight -> out_valid_o=0, result_o=0, inflight_o=0 same cycle.
//    After release: in_ready_o=1.
//  - Op sweep, nb_bits=32, nb_stages=2, out_ready_i=1: a=F0F0_00FF, b=FF00_0F0F, all 8 ops back-to-back.
//    Expect AND=F000_000F, OR=FFF0_0FFF, XOR=0FF0_0FF0, XNOR=F00F_F00F, NAND=0FFF_FFF0, NOR=000F_F000,
//    ANDN=00F0_00F0, PASSA=F0F0_00FF, each 2 cycles after its accept, 1/cycle.
//  - Backpressure fill: out_ready_i=0, push 3 ops -> 2 accepted, in_ready_o=0, inflight_o=2, result_o = first op held.
//    Raise out_ready_i -> results delivered in order.
//  - Simultaneous in/out when full: out_ready_i=1, in_valid_i=1 -> in_ready_o=1, inflight_o stays 2.
//  - Bubble collapse: stage 1 stalled with v[0]=0, push op -> accepted, inflight_o=2.
//  - Random: valid/ready 50% toggle, 10k ops, nb_stages in {1,3}, nb_bits in {1,32}.
//    Scoreboard vs logic_eval; check FIFO order and handshake stability.

Source files
------------

// File: rtl/riscv_logic_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: the function
// encoding and a single-bit evaluator that the top applies to every bit.
package riscv_logic_pkg;

    localparam int unsigned LOGIC_OP_W = 3;

    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } logic_op_t;

    // Every function is bitwise, so one bit position fully describes it;
    // this keeps the helper independent of the operand width.
    function automatic logic logic_eval(input logic_op_t op, input logic a, input logic b);
        logic r_s;
        case (op)
            OP_AND:   r_s = a & b;
            OP_OR:    r_s = a | b;
            OP_XOR:   r_s = a ^ b;
            OP_XNOR:  r_s = ~(a ^ b);
            OP_NAND:  r_s = ~(a & b);
            OP_NOR:   r_s = ~(a | b);
            OP_ANDN:  r_s = a & ~b;
            OP_PASSA: r_s = a;
            default:  r_s = a;
        endcase
        return r_s;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid+data slot of the result pipeline. Data is only overwritten when
// a valid item moves in, so an empty slot keeps its last value.
module logic_pipe_stage #(
    parameter int nb_bits = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic               valid_i,
    input  logic [nb_bits-1:0] data_i,
    output logic               valid_o,
    output logic [nb_bits-1:0] data_o
);

    logic               r_valid;
    logic [nb_bits-1:0] r_data;

    // Slot register: take the upstream item whenever this slot may advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_data  <= {nb_bits{1'b0}};
        end else if (load_i) begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_data <= data_i;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: function mux at the input, nb_stages
// valid/data slots with a collapsing ready chain, and an in-flight counter.
module logic_unit_pipe
    import riscv_logic_pkg::*;
#(
    parameter int nb_bits   = 32,
    parameter int nb_stages = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [LOGIC_OP_W-1:0]          op_i,
    input  logic [nb_bits-1:0]             a_i,
    input  logic [nb_bits-1:0]             b_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [nb_bits-1:0]             result_o,
    output logic [$clog2(nb_stages+1)-1:0] inflight_o,
    output logic                           busy_o
);

    localparam int CNT_W = $clog2(nb_stages + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic_op_t          w_op;
    logic [nb_bits-1:0] w_func;
    logic [nb_stages:0] w_rdy;
    logic [nb_stages-1:0] w_v;
    logic [nb_bits-1:0] w_d [nb_stages];
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [CNT_W-1:0]   w_inflight_next;
    logic [CNT_W-1:0]   r_inflight;
    logic               r_busy;

    assign w_op = logic_op_t'(op_i);

    // Function mux: evaluate the selected operation bit by bit.
    always_comb begin
        w_func = {nb_bits{1'b0}};
        for (int i = 0; i < nb_bits; i++) begin
            w_func[i] = logic_eval(w_op, a_i[i], b_i[i]);
        end
    end

    // Ready chain: a slot may advance if it is empty or everything after it moves.
    always_comb begin
        w_rdy            = {(nb_stages + 1){1'b0}};
        w_rdy[nb_stages] = out_ready_i;
        for (int k = nb_stages - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_v[k] | w_rdy[k+1];
        end
    end

    for (genvar k = 0; k < nb_stages; k++) begin : g_stage
        logic               w_vin;
        logic [nb_bits-1:0] w_din;
        if (k == 0) begin : g_first
            assign w_vin = in_valid_i;
            assign w_din = w_func;
        end else begin : g_next
            assign w_vin = w_v[k-1];
            assign w_din = w_d[k-1];
        end
        logic_pipe_stage #(.nb_bits(nb_bits)) u_stage (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .load_i  (w_rdy[k]),
            .valid_i (w_vin),
            .data_i  (w_din),
            .valid_o (w_v[k]),
            .data_o  (w_d[k])
        );
    end

    assign w_in_xfer  = in_valid_i & w_rdy[0];
    assign w_out_xfer = w_v[nb_stages-1] & out_ready_i;

    // Occupancy update: a simultaneous accept and deliver leaves the count unchanged.
    always_comb begin
        w_inflight_next = r_inflight;
        if (w_in_xfer && !w_out_xfer) begin
            w_inflight_next = r_inflight + CNT_ONE;
        end else if (!w_in_xfer && w_out_xfer) begin
            w_inflight_next = r_inflight - CNT_ONE;
        end else begin
            w_inflight_next = r_inflight;
        end
    end

    // Occupancy and busy registers, kept in step so busy never glitches.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= CNT_ZERO;
            r_busy     <= 1'b0;
        end else begin
            r_inflight <= w_inflight_next;
            r_busy     <= (w_inflight_next != CNT_ZERO);
        end
    end

    assign in_ready_o  = w_rdy[0];
    assign out_valid_o = w_v[nb_stages-1];
    assign result_o    = w_d[nb_stages-1];
    assign inflight_o  = r_inflight;
    assign busy_o      = r_busy;

endmodule
